// File: rtl/arbitro_escrita_banco.sv
// Round-robin write-port arbiter for the 32x32 register bank. It registers the granted write
// for one cycle and flags pending writes that match the current read addresses.
module arbitro_escrita_banco #(
  parameter int N_REG = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        v0,
  input  logic        v1,
  output logic        r0,
  output logic        r1,
  input  logic [5:0]  s0,
  input  logic [5:0]  s1,
  input  logic [31:0] d0,
  input  logic [31:0] d1,
  output logic        Write_UC,
  output logic [5:0]  S,
  output logic [31:0] Multiplexador_W_Data,
  input  logic [5:0]  OP1,
  input  logic [5:0]  OP2,
  output logic        fwd1,
  output logic        fwd2,
  output logic        erro_endereco
);

  // One extra bit so that N_REG = 64 (every 6-bit address valid) still compares correctly.
  localparam logic [6:0] NREG_LIM = 7'(N_REG);

  logic        ultimo_q,   ultimo_d;
  logic        write_uc_q, write_uc_d;
  logic [5:0]  s_q,        s_d;
  logic [31:0] data_q,     data_d;
  logic        erro_q,     erro_d;

  logic        grant0, grant1, accept, dest_ok;
  logic [5:0]  sel_s;
  logic [31:0] sel_d;

  // On a tie, the requester that did not win last time gets the port.
  // Gating with reset_n keeps both readies low while the block is held in reset.
  always_comb begin
    grant0  = reset_n & ~stall & v0 & (~v1 | ultimo_q);
    grant1  = reset_n & ~stall & v1 & (~v0 | ~ultimo_q);
    accept  = grant0 | grant1;
    sel_s   = grant1 ? s1 : s0;
    sel_d   = grant1 ? d1 : d0;
    dest_ok = ({1'b0, sel_s} < NREG_LIM);
  end

  always_comb begin
    ultimo_d   = ultimo_q;
    write_uc_d = 1'b0;
    s_d        = s_q;
    data_d     = data_q;
    erro_d     = erro_q;
    if (accept) begin
      ultimo_d   = grant1;
      write_uc_d = dest_ok;
      s_d        = sel_s;
      data_d     = sel_d;
      erro_d     = erro_q | ~dest_ok;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ultimo_q   <= 1'b1;
      write_uc_q <= 1'b0;
      s_q        <= 6'd0;
      data_q     <= 32'd0;
      erro_q     <= 1'b0;
    end else begin
      ultimo_q   <= ultimo_d;
      write_uc_q <= write_uc_d;
      s_q        <= s_d;
      data_q     <= data_d;
      erro_q     <= erro_d;
    end
  end

  always_comb begin
    r0                   = grant0;
    r1                   = grant1;
    Write_UC             = write_uc_q;
    S                    = s_q;
    Multiplexador_W_Data = data_q;
    erro_endereco        = erro_q;
    fwd1                 = write_uc_q & (s_q == OP1);
    fwd2                 = write_uc_q & (s_q == OP2);
  end

endmodule

// File: tb/tb_arbitro_escrita_banco.sv
// Scoreboard bench for arbitro_escrita_banco: each driven cycle pushes the write stage
// expected one cycle later, and each test task pops and compares inline.
module tb_arbitro_escrita_banco;

  localparam int N_REG = 32;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic        r0, r1;
  logic [5:0]  s0 = '0, s1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic        Write_UC;
  logic [5:0]  S;
  logic [31:0] Multiplexador_W_Data;
  logic [5:0]  OP1 = 6'h3F, OP2 = 6'h3F;
  logic        fwd1, fwd2, erro_endereco;

  arbitro_escrita_banco #(.N_REG(N_REG)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .v0(v0), .v1(v1), .r0(r0), .r1(r1),
    .s0(s0), .s1(s1), .d0(d0), .d1(d1),
    .Write_UC(Write_UC), .S(S), .Multiplexador_W_Data(Multiplexador_W_Data),
    .OP1(OP1), .OP2(OP2), .fwd1(fwd1), .fwd2(fwd2), .erro_endereco(erro_endereco)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        we;
    logic [5:0]  s;
    logic [31:0] d;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic        m_ult, m_err;
  logic [5:0]  m_s;
  logic [31:0] m_d;
  logic [1:0]  exp_r;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic reset_model();
    m_ult = 1'b1;
    m_err = 1'b0;
    m_s   = '0;
    m_d   = '0;
    sb.delete();
    sb.push_back('0);
  endtask

  // Drives one cycle of requests and pushes the write stage expected in the next cycle.
  task automatic drive(input logic iv0, input logic iv1, input logic ist,
                       input logic [5:0] is0, input logic [5:0] is1,
                       input logic [31:0] id0, input logic [31:0] id1);
    exp_t x;
    v0 = iv0; v1 = iv1; stall = ist;
    s0 = is0; s1 = is1; d0 = id0; d1 = id1;
    exp_r = 2'b00;
    if (!ist && iv0 && (!iv1 || m_ult)) exp_r = 2'b01;
    else if (!ist && iv1 && (!iv0 || !m_ult)) exp_r = 2'b10;
    x.we = 1'b0;
    if (exp_r != 2'b00) begin
      m_s   = exp_r[1] ? is1 : is0;
      m_d   = exp_r[1] ? id1 : id0;
      x.we  = (int'(m_s) < N_REG);
      m_err = m_err | ~x.we;
      m_ult = exp_r[1];
    end
    x.s   = m_s;
    x.d   = m_d;
    x.err = m_err;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    v0 = 1'b1; v1 = 1'b1; s0 = 6'd5; OP1 = 6'd0; OP2 = 6'd0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if ({r1, r0} !== 2'b00) begin
      n_bad++; $display("[TB] FAIL reset_ready: got %b required 00", {r1, r0});
    end
    n_cmp++;
    if ({Write_UC, S, Multiplexador_W_Data, erro_endereco} !== 40'd0) begin
      n_bad++; $display("[TB] FAIL reset_stage: got we=%b s=%0d d=%h err=%b required all 0",
                        Write_UC, S, Multiplexador_W_Data, erro_endereco);
    end
    n_cmp++;
    if ({fwd1, fwd2} !== 2'b00) begin
      n_bad++; $display("[TB] FAIL reset_fwd: got %b required 00", {fwd1, fwd2});
    end
    reset_model();
    OP1 = 6'h3F; OP2 = 6'h3F;
    v0 = 1'b0; v1 = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      drive(i == 1, 1'b0, 1'b0, 6'd5, 6'd0, 32'hDEADBEEF, 32'd0);
      @(negedge clock);
      e = sb.pop_front();
      n_cmp++;
      if ({r1, r0} !== exp_r) begin
        n_bad++; $display("[TB] FAIL first_grant[%0d]: got %b required %b", i, {r1, r0}, exp_r);
      end
      n_cmp++;
      if ({Write_UC, S, Multiplexador_W_Data, erro_endereco} !== e) begin
        n_bad++; $display("[TB] FAIL first_stage[%0d]: got %h required %h", i,
                          {Write_UC, S, Multiplexador_W_Data, erro_endereco}, e);
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_round_robin();
    // A lone requester-1 write leaves ultimo=1 so the tie sequence starts with requester 0.
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1'b0, 1'b1, 1'b0, 6'd1, 6'd2, 32'h0, 32'h2222_0000);
      else        drive(1'b1, 1'b1, 1'b0, 6'd1, 6'd2, 32'h1111_0000 + i, 32'h2222_0000 + i);
      @(negedge clock);
      e = sb.pop_front();
      n_cmp++;
      if ({r1, r0} !== exp_r) begin
        n_bad++; $display("[TB] FAIL rr_grant[%0d]: got %b required %b", i, {r1, r0}, exp_r);
      end
      n_cmp++;
      if ({Write_UC, S, Multiplexador_W_Data, erro_endereco} !== e) begin
        n_bad++; $display("[TB] FAIL rr_stage[%0d]: got %h required %h", i,
                          {Write_UC, S, Multiplexador_W_Data, erro_endereco}, e);
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      drive(i < 4, i < 4, i < 2, 6'd10, 6'd11, 32'hA000_0000 + i, 32'hB000_0000 + i);
      @(negedge clock);
      e = sb.pop_front();
      n_cmp++;
      if ({r1, r0} !== exp_r) begin
        n_bad++; $display("[TB] FAIL stall_grant[%0d]: got %b required %b", i, {r1, r0}, exp_r);
      end
      n_cmp++;
      if ({Write_UC, S, Multiplexador_W_Data, erro_endereco} !== e) begin
        n_bad++; $display("[TB] FAIL stall_stage[%0d]: got %h required %h", i,
                          {Write_UC, S, Multiplexador_W_Data, erro_endereco}, e);
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_bad_dest();
    for (int i = 0; i < 14; i++) begin
      if (i == 0)       drive(1'b0, 1'b1, 1'b0, 6'd0, 6'd40, 32'd0, 32'hBAD0_0040);
      else if (i == 11) drive(1'b0, 1'b1, 1'b0, 6'd0, 6'd3, 32'd0, 32'h0000_0333);
      else              drive(1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 32'd0, 32'd0);
      @(negedge clock);
      e = sb.pop_front();
      n_cmp++;
      if ({r1, r0} !== exp_r) begin
        n_bad++; $display("[TB] FAIL bad_grant[%0d]: got %b required %b", i, {r1, r0}, exp_r);
      end
      n_cmp++;
      if ({Write_UC, S, Multiplexador_W_Data, erro_endereco} !== e) begin
        n_bad++; $display("[TB] FAIL bad_stage[%0d]: got %h required %h", i,
                          {Write_UC, S, Multiplexador_W_Data, erro_endereco}, e);
      end
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_forwarding();
    logic [1:0] exp_f;
    for (int i = 0; i < 3; i++) begin
      OP1 = (i == 1) ? 6'd7 : 6'h3F;
      OP2 = (i == 1) ? 6'd8 : 6'h3F;
      drive(i == 0, 1'b0, 1'b0, 6'd7, 6'd0, 32'h7777_7777, 32'd0);
      @(negedge clock);
      e = sb.pop_front();
      exp_f = {e.we & (e.s == OP1), e.we & (e.s == OP2)};
      n_cmp++;
      if ({Write_UC, S, Multiplexador_W_Data, erro_endereco} !== e) begin
        n_bad++; $display("[TB] FAIL fwd_stage[%0d]: got %h required %h", i,
                          {Write_UC, S, Multiplexador_W_Data, erro_endereco}, e);
      end
      n_cmp++;
      if ({fwd1, fwd2} !== exp_f) begin
        n_bad++; $display("[TB] FAIL fwd_flags[%0d]: got %b required %b", i, {fwd1, fwd2}, exp_f);
      end
      @(posedge clock);
      #1;
    end
    OP1 = 6'h3F; OP2 = 6'h3F;
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 1'b0, 1'b0, 6'd9, 6'd0, 32'h0909_0909, 32'd0);
    @(negedge clock);
    e = sb.pop_front();
    n_cmp++;
    if ({r1, r0} !== exp_r) begin
      n_bad++; $display("[TB] FAIL mid_grant: got %b required %b", {r1, r0}, exp_r);
    end
    @(posedge clock);
    #1;
    v0 = 1'b0;
    e = sb.pop_front();
    n_cmp++;
    if ({Write_UC, S, Multiplexador_W_Data, erro_endereco} !== e) begin
      n_bad++; $display("[TB] FAIL mid_issue: got %h required %h",
                        {Write_UC, S, Multiplexador_W_Data, erro_endereco}, e);
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({Write_UC, S, Multiplexador_W_Data} !== 39'd0) begin
      n_bad++; $display("[TB] FAIL mid_async_clear: got we=%b s=%0d d=%h required all 0",
                        Write_UC, S, Multiplexador_W_Data);
    end
    reset_model();
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      drive(i == 0, i == 0, 1'b0, 6'd12, 6'd13, 32'hC0DE_0012, 32'hC0DE_0013);
      @(negedge clock);
      e = sb.pop_front();
      n_cmp++;
      if ({r1, r0} !== exp_r) begin
        n_bad++; $display("[TB] FAIL post_grant[%0d]: got %b required %b", i, {r1, r0}, exp_r);
      end
      n_cmp++;
      if ({Write_UC, S, Multiplexador_W_Data, erro_endereco} !== e) begin
        n_bad++; $display("[TB] FAIL post_stage[%0d]: got %h required %h", i,
                          {Write_UC, S, Multiplexador_W_Data, erro_endereco}, e);
      end
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_bad_dest();
    test_forwarding();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/arbitro_escrita_banco.md
# arbitro_escrita_banco

Write-port arbiter and write-stage register for the 32×32-bit register bank. It shares the bank's single write port between two writeback requesters: requester 0 is the ULA and requester 1 is memory load. Arbitration is round-robin. Each accepted write is registered for one cycle, then driven onto the bank's write enable, destination and data inputs. The block also flags in-flight writes that match the current read addresses, so the datapath can forward around the pending write.

## Interface
- N_REG, 32, number of implemented registers; destinations with value ≥ N_REG are invalid
- clock  in  1  rising-edge clock shared with the register bank
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  from UC; when 1, no request is accepted
- v0, v1  in  1  request valid, requester 0 (ULA) / 1 (memory)
- r0, r1  out  1  request ready (combinational); a write is accepted on a cycle with vX & rX
- s0, s1  in  6  destination register per requester
- d0, d1  in  32  write data per requester
- Write_UC  out  1  registered write enable to the register bank
- S  out  6  registered destination to the register bank
- Multiplexador_W_Data  out  32  registered write data to the register bank
- OP1, OP2  in  6  current read addresses (same values driven to the bank)
- fwd1, fwd2  out  1  in-flight write targets OP1 / OP2
- erro_endereco  out  1  sticky flag: a write with an invalid destination was accepted

## Operation
- Round-robin pointer `ultimo` records the last granted requester (0 or 1). Reset value is 1, so requester 0 wins the first tie.
- Grant rules, evaluated combinationally each cycle:
  - stall=1: r0=r1=0.
  - Only v0=1: r0=1, r1=0.
  - Only v1=1: r1=1, r0=0.
  - v0=v1=1: grant the requester ≠ ultimo; the other ready is 0.
  - Neither valid: r0=r1=0.
- At most one of r0/r1 is 1 in any cycle. rX is never 1 while vX=0.
- `ultimo` updates only on an accepted write; it holds on stall or idle cycles.
- On acceptance, the chosen requester's (sX, dX) is captured into the write stage at the next rising edge.
- Write_UC is set to 1 only if sX < N_REG.
- If sX ≥ N_REG:
  - the handshake still completes;
  - Write_UC=0 on the following cycle (the write is dropped);
  - erro_endereco is set and stays 1 until reset.
- With no acceptance, Write_UC is set to 0 at the next edge. S and Multiplexador_W_Data hold their last values.
- The write port never backpressures, so the stage accepts a new request every cycle.
- Forwarding, combinational:
  - fwd1 = Write_UC & (S == OP1).
  - fwd2 = Write_UC & (S == OP2).
  - The datapath uses Multiplexador_W_Data as the forwarded value.
- A requester may hold vX with changing sX/dX. Only the values present on the accept cycle are used.

## Timing
- Reset (reset_n=0, asynchronous): Write_UC=0, S=0, Multiplexador_W_Data=0, erro_endereco=0, ultimo=1.
  - While in reset, r0=r1=0 and fwd1=fwd2=0.
  - Deassertion is sampled at the next rising edge.
- Reset asserted mid-operation: an in-flight write is discarded immediately (Write_UC drops without waiting for a clock edge).
- Latency, for a request accepted in cycle N:
  - Write_UC, S and Multiplexador_W_Data are valid throughout cycle N+1.
  - The bank writes at the rising edge ending cycle N+1.
  - A read of that register returns the new value from cycle N+2.
  - fwd covers cycle N+1.
- Throughput: one write per cycle. With both requesters continuously valid, grants alternate 0,1,0,1…
- stall asserted in cycle N blocks acceptance in cycle N only. A write accepted in N−1 still issues in cycle N.

## Test plan
- Reset then idle. Required: all outputs 0 and r0=r1=0. Then v0=1, s0=5, d0=0xDEADBEEF in cycle 1. Required: r0=1 in cycle 1; Write_UC=1, S=5, data=0xDEADBEEF in cycle 2; Write_UC=0 in cycle 3.
- v0=v1=1 held for 4 cycles, s0=1, s1=2. Required: grants 0,1,0,1; S sequence 1,2,1,2 one cycle later; Write_UC=1 for 4 consecutive cycles.
- Both valid with stall=1 for 2 cycles, then stall=0. Required: r0=r1=0 and Write_UC=0 during stall; requester 0 is granted first after release.
- v1=1, s1=40. Required: r1=1; Write_UC=0 next cycle; erro_endereco=1 and still 1 after 10 idle cycles. Then a valid write with s1=3 must still issue normally.
- Accept s0=7, and in the next cycle set OP1=7, OP2=8. Required: fwd1=1, fwd2=0 in that cycle; both 0 in the cycle after.
- Pull reset_n low between an accept and the following edge. Required: Write_UC=0 immediately; no bank write occurs; ultimo=1 after release.
